// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step/rate controller.
// Holds the FSM state encoding and the rate_sel divider shift table.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_STEP = 2'd3
    } state_t;

    localparam int unsigned RATE_SHIFT_0 = 0;
    localparam int unsigned RATE_SHIFT_1 = 4;
    localparam int unsigned RATE_SHIFT_2 = 10;

    // Number of low divider bits that must all be ones for a tick; the
    // slowest setting uses the full divider width.
    function automatic int unsigned rate_shift(input logic [1:0] sel, input int unsigned ctr_w);
        case (sel)
            2'd0:    return RATE_SHIFT_0;
            2'd1:    return RATE_SHIFT_1;
            2'd2:    return RATE_SHIFT_2;
            default: return ctr_w;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop synchroniser followed by a stability counter.
// The output follows the synchronised input after DEB_CYC consecutive mismatching cycles.
module sw_debounce #(
    parameter int unsigned DEB_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            dout       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            // Any cycle where the input agrees with the output restarts the count.
            if (sync_2 != dout) begin
                if (stable_cnt == CNT_LAST) begin
                    dout       <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/rate controller for the core: turns debounced board switches into a
// single-cycle clock-enable strobe, a held CPU reset and a strobe counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_HOLD | CPU held in reset; hold counter runs once rst_sw released
// S_RUN  | free running, cpu_ce follows the rate divider tick
// S_HALT | stopped, waiting for a step edge or run_sw
// S_STEP | issue exactly one cpu_ce strobe, then back to S_HALT
module cpu_clk_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CTR_W    = 17,
    parameter int unsigned DEB_CYC  = 50000,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        rst_sw,
    input  logic [1:0]  rate_sel,
    output logic        cpu_ce,
    output logic        cpu_reset,
    output logic [1:0]  state,
    output logic [15:0] ce_cnt
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic run_deb;
    logic step_deb;
    logic rst_deb;
    logic step_prev;
    logic step_rise;

    state_t             cur_state;
    state_t             nxt_state;
    logic               ce_nxt;
    logic               rst_nxt;
    logic               hold_exit;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [CTR_W-1:0]   divider;
    logic [CTR_W-1:0]   rate_mask;
    int unsigned        rate_k;
    logic               tick;

    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_run (
        .clk   (clk),
        .reset (reset),
        .din   (run_sw),
        .dout  (run_deb)
    );

    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_step (
        .clk   (clk),
        .reset (reset),
        .din   (step_btn),
        .dout  (step_deb)
    );

    sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb_rst (
        .clk   (clk),
        .reset (reset),
        .din   (rst_sw),
        .dout  (rst_deb)
    );

    assign step_rise = step_deb & ~step_prev;
    assign state     = cur_state;

    // A shift of zero yields an empty mask, so the compare is always true.
    always_comb begin
        rate_k = rate_shift(rate_sel, CTR_W);
        rate_mask = '0;
        for (int unsigned i = 0; i < CTR_W; i++) begin
            rate_mask[i] = (i < rate_k);
        end
    end

    assign tick = ((divider & rate_mask) == rate_mask);

    always_comb begin
        nxt_state = cur_state;
        ce_nxt    = 1'b0;
        rst_nxt   = 1'b0;
        hold_nxt  = '0;
        hold_exit = 1'b0;
        if (rst_deb) begin
            nxt_state = S_HOLD;
            rst_nxt   = 1'b1;
        end else begin
            case (cur_state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        nxt_state = run_deb ? S_RUN : S_HALT;
                        hold_exit = 1'b1;
                    end else begin
                        rst_nxt  = 1'b1;
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // The tick seen on the run-falling cycle still strobes.
                    ce_nxt = tick;
                    if (!run_deb) begin
                        nxt_state = S_HALT;
                    end
                end
                S_HALT: begin
                    if (step_rise) begin
                        nxt_state = S_STEP;
                    end else if (run_deb) begin
                        nxt_state = S_RUN;
                    end
                end
                S_STEP: begin
                    ce_nxt    = 1'b1;
                    nxt_state = S_HALT;
                end
                default: begin
                    nxt_state = S_HOLD;
                    rst_nxt   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_HOLD;
            cpu_ce    <= 1'b0;
            cpu_reset <= 1'b1;
            ce_cnt    <= '0;
            divider   <= '0;
            hold_cnt  <= '0;
            step_prev <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cpu_ce    <= ce_nxt;
            cpu_reset <= rst_nxt;
            hold_cnt  <= hold_nxt;
            step_prev <= step_deb;
            divider   <= hold_exit ? '0 : divider + 1'b1;
            if (hold_exit) begin
                ce_cnt <= '0;
            end else if (ce_nxt) begin
                ce_cnt <= ce_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: table-driven phases, hand sequences for
// multi-cycle corners, and randomized stimulus against a cycle-level reference model.
module tb_cpu_clk_ctrl;

    localparam int CTR_W = 6;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int M_HOLD = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_sw, step_btn, rst_sw;
    logic [1:0]  rate_sel;
    logic        cpu_ce, cpu_reset;
    logic [1:0]  state;
    logic [15:0] ce_cnt;

    int checks = 0;
    int errors = 0;

    cpu_clk_ctrl #(.CTR_W(CTR_W), .DEB_CYC(DEB), .HOLD_CYC(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .rst_sw    (rst_sw),
        .rate_sel  (rate_sel),
        .cpu_ce    (cpu_ce),
        .cpu_reset (cpu_reset),
        .state     (state),
        .ce_cnt    (ce_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: inputs indexed 0 run, 1 step, 2 rst.
    int m_state, m_cnt, m_hold, m_div;
    bit m_ce, m_rst, m_stp_prev;
    bit m_s1[3], m_s2[3], m_deb[3];
    bit m_hist[3][DEB];

    function automatic int tick_bits(input logic [1:0] sel);
        int k;
        case (sel)
            2'd0: k = 0;
            2'd1: k = 4;
            2'd2: k = 10;
            default: k = CTR_W;
        endcase
        return (k > CTR_W) ? CTR_W : k;
    endfunction

    task automatic model_step();
        bit raw[3];
        int period, n_state;
        bit tick, rise, n_ce, n_rst, leave, all_diff;
        int n_hold;
        if (!reset) begin
            m_state = M_HOLD; m_ce = 0; m_rst = 1; m_cnt = 0;
            m_hold = 0; m_div = 0; m_stp_prev = 0;
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0;
                for (int j = 0; j < DEB; j++) m_hist[i][j] = 0;
            end
            return;
        end
        raw[0] = run_sw; raw[1] = step_btn; raw[2] = rst_sw;
        period = 1 << tick_bits(rate_sel);
        tick = ((m_div % period) == period - 1);
        rise = m_deb[1] && !m_stp_prev;
        n_state = m_state; n_ce = 0; n_rst = 0; n_hold = 0; leave = 0;
        if (m_deb[2]) begin
            n_state = M_HOLD; n_rst = 1;
        end else if (m_state == M_HOLD) begin
            if (m_hold == HOLD - 1) begin
                leave = 1;
                n_state = m_deb[0] ? M_RUN : M_HALT;
            end else begin
                n_hold = m_hold + 1; n_rst = 1;
            end
        end else if (m_state == M_RUN) begin
            n_ce = tick;
            if (!m_deb[0]) n_state = M_HALT;
        end else if (m_state == M_HALT) begin
            if (rise) n_state = M_STEP;
            else if (m_deb[0]) n_state = M_RUN;
        end else begin
            n_ce = 1; n_state = M_HALT;
        end
        m_div = leave ? 0 : (m_div + 1) % (1 << CTR_W);
        if (leave) m_cnt = 0;
        else if (n_ce) m_cnt = (m_cnt + 1) % 65536;
        m_state = n_state; m_ce = n_ce; m_rst = n_rst; m_hold = n_hold;
        m_stp_prev = m_deb[1];
        // Debounced level flips once the last DEB synchronised samples all disagree with it.
        for (int i = 0; i < 3; i++) begin
            for (int j = DEB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_s2[i];
            all_diff = 1;
            for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_deb[i]) all_diff = 0;
            if (all_diff) m_deb[i] = !m_deb[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        model_step();
        @(posedge clk);
        #1;
        chk("model_cpu_ce", int'(cpu_ce), int'(m_ce));
        chk("model_cpu_reset", int'(cpu_reset), int'(m_rst));
        chk("model_state", int'(state), m_state);
        chk("model_ce_cnt", int'(ce_cnt), m_cnt);
    endtask

    typedef struct {
        bit         run;
        bit         stp;
        bit         rs;
        logic [1:0] rate;
        int         cyc;
        int         exp_state;
        int         exp_rst;
        int         exp_ce;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            run_sw = vecs[i].run; step_btn = vecs[i].stp;
            rst_sw = vecs[i].rs;  rate_sel = vecs[i].rate;
            repeat (vecs[i].cyc) step_clk();
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
            chk($sformatf("vec%0d_cpu_reset", i), int'(cpu_reset), vecs[i].exp_rst);
            if (vecs[i].exp_ce >= 0)
                chk($sformatf("vec%0d_cpu_ce", i), int'(cpu_ce), vecs[i].exp_ce);
            if (vecs[i].exp_cnt >= 0)
                chk($sformatf("vec%0d_ce_cnt", i), int'(ce_cnt), vecs[i].exp_cnt);
        end
    endtask

    task automatic measure_period(input string name, input int cycles, input int exp_period,
                                  input int min_intervals);
        int last, n_int;
        last = -1; n_int = 0;
        for (int c = 0; c < cycles; c++) begin
            step_clk();
            if (cpu_ce) begin
                if (last >= 0) begin
                    chk(name, c - last, exp_period);
                    n_int++;
                end
                last = c;
            end
        end
        chk({name, "_count_ok"}, int'(n_int >= min_intervals), 1);
    endtask

    initial begin
        int pulses, base;
        int hold_left[3];
        bit val[3];

        //            run stp rs rate cyc state  rst ce  cnt
        vecs[0]  = '{1, 0, 0, 2'd0, 7,  M_HOLD, 1, 0,  0};
        vecs[1]  = '{1, 0, 0, 2'd0, 1,  M_RUN,  0, 0,  0};
        vecs[2]  = '{1, 0, 0, 2'd0, 20, M_RUN,  0, 1,  20};
        vecs[3]  = '{0, 0, 0, 2'd3, 6,  M_RUN,  0, -1, -1};
        vecs[4]  = '{0, 0, 0, 2'd3, 1,  M_HALT, 0, -1, -1};
        vecs[5]  = '{1, 0, 0, 2'd0, 7,  M_RUN,  0, 0,  -1};
        vecs[6]  = '{1, 0, 1, 2'd0, 6,  M_RUN,  0, 1,  -1};
        vecs[7]  = '{1, 0, 1, 2'd0, 1,  M_HOLD, 1, 0,  -1};
        vecs[8]  = '{1, 0, 1, 2'd0, 5,  M_HOLD, 1, 0,  -1};
        vecs[9]  = '{1, 0, 0, 2'd0, 13, M_HOLD, 1, 0,  -1};
        vecs[10] = '{1, 0, 0, 2'd0, 1,  M_RUN,  0, 0,  0};

        reset = 1'b0; run_sw = 1'b1; step_btn = 1'b0; rst_sw = 1'b0; rate_sel = 2'd0;
        repeat (3) step_clk();
        chk("reset_state", int'(state), M_HOLD);
        chk("reset_cpu_reset", int'(cpu_reset), 1);
        chk("reset_cpu_ce", int'(cpu_ce), 0);
        chk("reset_ce_cnt", int'(ce_cnt), 0);
        reset = 1'b1;

        apply_vecs(0, 2);

        rate_sel = 2'd1;
        measure_period("rate1_period", 200, 16, 10);
        rate_sel = 2'd3;
        measure_period("rate3_period", 260, 64, 3);

        apply_vecs(3, 4);

        // Held step press: exactly one strobe.
        base = m_cnt; pulses = 0;
        step_btn = 1'b1;
        repeat (10) begin step_clk(); pulses += int'(cpu_ce); end
        step_btn = 1'b0;
        repeat (10) begin step_clk(); pulses += int'(cpu_ce); end
        chk("step_one_pulse", pulses, 1);
        chk("step_cnt_inc", int'(ce_cnt), (base + 1) % 65536);
        chk("step_back_halt", int'(state), M_HALT);

        // Two-cycle glitch must be filtered.
        pulses = 0;
        step_btn = 1'b1;
        repeat (2) begin step_clk(); pulses += int'(cpu_ce); end
        step_btn = 1'b0;
        repeat (12) begin step_clk(); pulses += int'(cpu_ce); end
        chk("glitch_no_pulse", pulses, 0);

        apply_vecs(5, 10);

        // ce_cnt wrap at rate 0.
        repeat (65535) step_clk();
        chk("cnt_at_ffff", int'(ce_cnt), 16'hFFFF);
        step_clk();
        chk("cnt_wrap_zero", int'(ce_cnt), 0);
        chk("cnt_wrap_ce", int'(cpu_ce), 1);

        // Block reset in the middle of STEP.
        run_sw = 1'b0;
        repeat (7) step_clk();
        chk("pre_step_halt", int'(state), M_HALT);
        step_btn = 1'b1;
        repeat (7) step_clk();
        chk("in_step_state", int'(state), M_STEP);
        reset = 1'b0;
        step_clk();
        chk("midstep_rst_state", int'(state), M_HOLD);
        chk("midstep_rst_cpu_ce", int'(cpu_ce), 0);
        chk("midstep_rst_cpu_reset", int'(cpu_reset), 1);
        chk("midstep_rst_ce_cnt", int'(ce_cnt), 0);
        reset = 1'b1; step_btn = 1'b0;

        // Randomized stimulus; inputs held for random stretches so debouncing resolves.
        for (int i = 0; i < 3; i++) begin hold_left[i] = 0; val[i] = 0; end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_left[i] == 0) begin
                    val[i] = (i == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
                    hold_left[i] = $urandom_range(1, 12);
                end else begin
                    hold_left[i]--;
                end
            end
            run_sw = val[0]; step_btn = val[1]; rst_sw = val[2];
            if ($urandom_range(0, 63) == 0) rate_sel = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step_clk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
